// File: rtl/srambank_req_ctrl_pkg.sv
// Shared configuration for the srambank request front-end.
// Holds the bank geometry, the response FIFO depth, the derived address widths,
// the bank-index type and a one-hot decode helper.
package srambank_req_ctrl_pkg;

    localparam int unsigned NBANKS    = 4;   // number of srambank instances (power of two)
    localparam int unsigned ROWS_AW   = 8;   // per-bank row address width
    localparam int unsigned DW        = 36;  // data width
    localparam int unsigned RSP_DEPTH = 2;   // response FIFO depth (power of two)

    localparam int unsigned BANK_AW = $clog2(NBANKS);
    localparam int unsigned REQ_AW  = ROWS_AW + BANK_AW;
    localparam int unsigned CNT_W   = $clog2(RSP_DEPTH) + 1;

    typedef logic [BANK_AW-1:0] bank_idx_t;

    function automatic logic [NBANKS-1:0] bank_onehot(input bank_idx_t idx);
        logic [NBANKS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/srambank_rsp_fifo.sv
// Synchronous circular FIFO holding read responses.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (clears pointers, count, storage)
//   push_i      write wdata_i at the tail
//   wdata_i     data to push
//   pop_i       drop the head entry (ignored when empty)
//   rdata_o     head entry, always driven
//   valid_o     FIFO not empty
//   count_o     occupancy before this cycle's push/pop
module srambank_rsp_fifo #(
    parameter int unsigned Width = 36,
    parameter int unsigned Depth = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             empty, full, pop_eff;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW+1)'(Depth));
    assign pop_eff = pop_i & ~empty;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_eff) begin
            count_d = count_q + (PtrW+1)'(1);
        end else if (!push_i && pop_eff) begin
            count_d = count_q - (PtrW+1)'(1);
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;

    // The upstream credit check must make this unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i));

endmodule

// File: rtl/srambank_req_ctrl.sv
// Request front-end for a set of srambank instances.
// Decodes {bank,row} requests onto the shared bank bus with a one-hot bank select,
// captures the selected bank's dataout one cycle after a read accept and returns
// read data in order through a credit-protected response FIFO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_*_i/_o        valid/ready request channel (write flag, {bank,row} address, data)
//   rsp_*_i/_o        valid/ready read-response channel
//   mem_*_o           shared bank address/data/strobes and one-hot bank select
//   mem_dataout_i     concatenated bank dataout, bank b at [b*DW +: DW]
module srambank_req_ctrl
    import srambank_req_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [REQ_AW-1:0]    req_addr_i,
    input  logic [DW-1:0]        req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DW-1:0]        rsp_rdata_o,
    output logic [ROWS_AW-1:0]   mem_address_o,
    output logic [DW-1:0]        mem_wd_o,
    output logic [NBANKS-1:0]    mem_banksel_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    input  logic [NBANKS*DW-1:0] mem_dataout_i
);

    bank_idx_t          req_bank;
    logic [ROWS_AW-1:0] req_row;
    logic               rd_pend_q, rd_pend_d;
    bank_idx_t          rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occ;
    logic               credit_ok, grant, accept;
    logic [DW-1:0]      cap_data;

    assign req_bank = req_addr_i[REQ_AW-1 -: BANK_AW];
    assign req_row  = req_addr_i[ROWS_AW-1:0];

    always_comb begin
        // Occupancy excludes this cycle's pop so rsp_ready never reaches req_ready.
        occ       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
        credit_ok = (occ < (CNT_W+1)'(RSP_DEPTH));
        grant     = req_write_i | credit_ok;
        // rst_n only gates the outputs; internal state is cleared by the async reset.
        req_ready_o = rst_n & grant;
        accept      = req_valid_i & req_ready_o;

        mem_banksel_o = '0;
        mem_address_o = '0;
        mem_wd_o      = '0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        if (accept) begin
            mem_banksel_o = bank_onehot(req_bank);
            mem_address_o = req_row;
            mem_wd_o      = req_wdata_i;
            mem_read_o    = ~req_write_i;
            mem_write_o   = req_write_i;
        end

        rd_pend_d = req_valid_i & grant & ~req_write_i;
        rd_bank_d = rd_pend_d ? req_bank : rd_bank_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Bank dataout holds until the next read, so an intervening write is harmless.
    assign cap_data = mem_dataout_i[rd_bank_q*DW +: DW];

    srambank_rsp_fifo #(
        .Width (DW),
        .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_pend_q),
        .wdata_i (cap_data),
        .pop_i   (rsp_valid_o & rsp_ready_i),
        .rdata_o (rsp_rdata_o),
        .valid_o (rsp_valid_o),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_srambank_req_ctrl.sv
// Self-checking bench for srambank_req_ctrl with a behavioural model of the banks.
module tb_srambank_req_ctrl;
    import srambank_req_ctrl_pkg::*;

    logic                 clk, rst_n;
    logic                 req_valid, req_ready, req_write;
    logic [REQ_AW-1:0]    req_addr;
    logic [DW-1:0]        req_wdata;
    logic                 rsp_valid, rsp_ready;
    logic [DW-1:0]        rsp_rdata;
    logic [ROWS_AW-1:0]   mem_address;
    logic [DW-1:0]        mem_wd;
    logic [NBANKS-1:0]    mem_banksel;
    logic                 mem_read, mem_write;
    logic [NBANKS*DW-1:0] mem_dataout;

    logic [DW-1:0] bank_mem [NBANKS][1<<ROWS_AW];
    logic [DW-1:0] bank_dout [NBANKS];
    logic [DW-1:0] ref_mem [1<<REQ_AW];
    logic [DW-1:0] exp_q [$];
    int            checks, failures;
    bit            mon_en;

    srambank_req_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .mem_address_o (mem_address),
        .mem_wd_o      (mem_wd),
        .mem_banksel_o (mem_banksel),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .mem_dataout_i (mem_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: samples on the accepting edge, dataout changes only on reads.
    always @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (mem_banksel[b]) begin
                if (mem_write) bank_mem[b][mem_address] <= mem_wd;
                if (mem_read)  bank_dout[b] <= bank_mem[b][mem_address];
            end
        end
    end

    always_comb begin
        mem_dataout = '0;
        for (int b = 0; b < NBANKS; b++) begin
            mem_dataout[b*DW +: DW] = bank_dout[b];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response scoreboard: every handshake must match the oldest expected read.
    always @(negedge clk) begin
        if (mon_en && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got 0x%0h with no read outstanding", rsp_rdata);
            end else begin
                chk("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_req(input logic w, input logic [REQ_AW-1:0] a, input logic [DW-1:0] d,
                          input int max_wait, output int waited);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        waited    = 0;
        #1;
        while (!req_ready && waited < max_wait) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: addr 0x%0h not accepted within %0d cycles", a, max_wait);
        end else begin
            chk("acc_banksel", 64'(mem_banksel), 64'(1) << a[REQ_AW-1 -: BANK_AW]);
            chk("acc_addr", 64'(mem_address), 64'(a[ROWS_AW-1:0]));
            chk("acc_rw", 64'({mem_read, mem_write}), w ? 64'd1 : 64'd2);
            if (w) ref_mem[a] = d;
            else   exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses missing after %0d cycles", exp_q.size(), n);
        end
    endtask

    typedef struct {
        logic               valid;
        logic               write;
        logic [REQ_AW-1:0]  addr;
        logic [DW-1:0]      wdata;
        logic               rsp_rdy;
        logic               e_ready;
        logic [NBANKS-1:0]  e_banksel;
        logic [ROWS_AW-1:0] e_maddr;
        logic [DW-1:0]      e_wd;
        logic               e_read;
        logic               e_write;
        logic               e_rvalid;
        logic [DW-1:0]      e_rdata;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vec [NVEC];

    initial begin
        int w, total;
        logic [REQ_AW-1:0] a;
        logic [DW-1:0]     d;

        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        for (int i = 0; i < (1 << REQ_AW); i++) ref_mem[i] = '0;

        //          vld   wr    addr     wdata           rrdy | rdy  bsel     maddr  wd              rd    wr    rv    rdata
        vec[0] = '{1'b1, 1'b1, 10'h2A5, 36'h9_1234_5678, 1'b1, 1'b1, 4'b0100, 8'hA5, 36'h9_1234_5678, 1'b0, 1'b1, 1'b0, 36'h0};
        vec[1] = '{1'b1, 1'b0, 10'h2A5, 36'h0,           1'b1, 1'b1, 4'b0100, 8'hA5, 36'h0,           1'b1, 1'b0, 1'b0, 36'h0};
        vec[2] = '{1'b0, 1'b0, 10'h000, 36'h0,           1'b1, 1'b1, 4'b0000, 8'h00, 36'h0,           1'b0, 1'b0, 1'b0, 36'h0};
        vec[3] = '{1'b0, 1'b0, 10'h000, 36'h0,           1'b1, 1'b1, 4'b0000, 8'h00, 36'h0,           1'b0, 1'b0, 1'b1, 36'h9_1234_5678};
        vec[4] = '{1'b1, 1'b1, 10'h011, 36'h0_AAAA_0000, 1'b1, 1'b1, 4'b0001, 8'h11, 36'h0_AAAA_0000, 1'b0, 1'b1, 1'b0, 36'h0};
        vec[5] = '{1'b1, 1'b1, 10'h123, 36'h1_BBBB_1111, 1'b1, 1'b1, 4'b0010, 8'h23, 36'h1_BBBB_1111, 1'b0, 1'b1, 1'b0, 36'h0};
        vec[6] = '{1'b1, 1'b1, 10'h200, 36'h2_CCCC_2222, 1'b1, 1'b1, 4'b0100, 8'h00, 36'h2_CCCC_2222, 1'b0, 1'b1, 1'b0, 36'h0};
        vec[7] = '{1'b1, 1'b1, 10'h3FF, 36'hF_DDDD_3333, 1'b1, 1'b1, 4'b1000, 8'hFF, 36'hF_DDDD_3333, 1'b0, 1'b1, 1'b0, 36'h0};
        vec[8] = '{1'b0, 1'b1, 10'h3FF, 36'h0_0000_0123, 1'b1, 1'b1, 4'b0000, 8'h00, 36'h0,           1'b0, 1'b0, 1'b0, 36'h0};

        // Reset state with a write request presented.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h2A5;
        req_wdata = 36'h9_1234_5678;
        rsp_ready = 1'b1;
        #3;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_banksel", 64'(mem_banksel), 64'd0);
        chk("reset_mem_write", 64'(mem_write), 64'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors: write, read-after-write latency, bank decode, gating.
        for (int i = 0; i < NVEC; i++) begin
            req_valid = vec[i].valid;
            req_write = vec[i].write;
            req_addr  = vec[i].addr;
            req_wdata = vec[i].wdata;
            rsp_ready = vec[i].rsp_rdy;
            #1;
            chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vec[i].e_ready));
            chk($sformatf("v%0d_banksel", i), 64'(mem_banksel), 64'(vec[i].e_banksel));
            chk($sformatf("v%0d_mem_address", i), 64'(mem_address), 64'(vec[i].e_maddr));
            chk($sformatf("v%0d_mem_wd", i), 64'(mem_wd), 64'(vec[i].e_wd));
            chk($sformatf("v%0d_mem_read", i), 64'(mem_read), 64'(vec[i].e_read));
            chk($sformatf("v%0d_mem_write", i), 64'(mem_write), 64'(vec[i].e_write));
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'(vec[i].e_rvalid));
            if (vec[i].e_rvalid) begin
                chk($sformatf("v%0d_rsp_rdata", i), 64'(rsp_rdata), 64'(vec[i].e_rdata));
            end
            if (vec[i].valid && vec[i].write && vec[i].e_ready) ref_mem[vec[i].addr] = vec[i].wdata;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        mon_en    = 1'b1;

        // Credit: with the consumer stalled only two reads fit; writes still pass.
        rsp_ready = 1'b0;
        do_req(1'b0, 10'h011, 36'h0, 4, w);
        chk("cr_rd0_wait", 64'(w), 64'd0);
        do_req(1'b0, 10'h123, 36'h0, 4, w);
        chk("cr_rd1_wait", 64'(w), 64'd0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h200;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("cr_blocked_ready", 64'(req_ready), 64'd0);
            chk("cr_blocked_banksel", 64'(mem_banksel), 64'd0);
            chk("cr_hold_valid", 64'(rsp_valid), 64'd1);
            chk("cr_hold_rdata", 64'(rsp_rdata), 64'h0_AAAA_0000);
            @(posedge clk);
        end
        #1;
        do_req(1'b1, 10'h1FE, 36'h5_5555_5555, 4, w);
        chk("cr_wr_wait", 64'(w), 64'd0);
        // The pop in the first ready cycle must not grant credit in that same cycle.
        rsp_ready = 1'b1;
        do_req(1'b0, 10'h200, 36'h0, 4, w);
        chk("cr_rd2_wait", 64'(w), 64'd1);
        do_req(1'b0, 10'h3FF, 36'h0, 4, w);
        chk("cr_rd3_wait", 64'(w), 64'd0);
        drain(20);

        // Streaming reads over two banks: two accepts per three cycles, pointers wrap.
        for (int i = 0; i < 40; i++) begin
            a = {1'b0, 1'(i % 2), 8'(i * 7 + 3)};
            d = 36'(i) * 36'h1_0203_0405 + 36'h11;
            do_req(1'b1, a, d, 4, w);
        end
        total = 0;
        for (int i = 0; i < 40; i++) begin
            a = {1'b0, 1'(i % 2), 8'(i * 7 + 3)};
            do_req(1'b0, a, 36'h0, 4, w);
            total += w;
        end
        chk("stream_stalls", 64'(total), 64'd19);
        drain(20);

        // Read bank 3 then overwrite the same row on the very next cycle.
        do_req(1'b1, 10'h3AB, 36'hA_0000_0001, 4, w);
        do_req(1'b0, 10'h3AB, 36'h0, 4, w);
        do_req(1'b1, 10'h3AB, 36'hB_0000_0002, 4, w);
        do_req(1'b0, 10'h3AB, 36'h0, 4, w);
        drain(20);

        // Reset with one response buffered and one read in flight.
        rsp_ready = 1'b0;
        do_req(1'b0, 10'h011, 36'h0, 4, w);
        do_req(1'b0, 10'h123, 36'h0, 4, w);
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
